// File: rtl/dmem_pkg.sv
// Shared widths, default sizing and FSM state type for the data memory slice.
package dmem_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int CNT_W       = 4;
  localparam int DEF_LATENCY = 5;
  localparam int DEF_DEPTH   = 256;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/data_memory_if.sv
// CPU-side load/store bus of the data memory: strobes, address, data and stall.
interface data_memory_if;
  import dmem_pkg::*;

  logic  read;
  logic  write;
  addr_t address;
  data_t writedata;
  data_t readdata;
  logic  busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );

endinterface

// File: rtl/dmem_array.sv
// Byte storage: one synchronous write port, one asynchronous read port, addresses wrap modulo DEPTH.
// Array clear on reset is enabled by defining DMEM_CLEAR_ON_RESET_EN.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  addr_t rd_addr,
  output data_t rd_data
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  data_t         mem [DEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;

  assign wr_idx = IW'(32'(wr_addr) % DEPTH);
  assign rd_idx = IW'(32'(rd_addr) % DEPTH);

`ifdef DMEM_CLEAR_ON_RESET_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_idx] <= wr_data;
    end
  end
`else
  // Contents survive reset; a write is simply suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[wr_idx] <= wr_data;
    end
  end
`endif

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/data_memory.sv
// Fixed-latency data memory: accepts one load/store at a time and stalls the CPU until it completes.
// Optional array clear on reset via DMEM_CLEAR_ON_RESET_EN (see dmem_array).
module data_memory
  import dmem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input logic          clk,
  input logic          rst,
  data_memory_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  addr_t            lat_addr;
  data_t            lat_data;
  logic             lat_write;
  data_t            readdata_q;
  data_t            rd_data;
  logic             done;
  logic             array_we;

  assign done     = (state == ACCESS) && (cnt == LAST);
  assign array_we = done && lat_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_write  <= 1'b0;
      readdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            state     <= ACCESS;
            cnt       <= '0;
            lat_addr  <= bus.address;
            lat_data  <= bus.writedata;
            // Write wins when both strobes are up, so READDATA stays put.
            lat_write <= bus.write;
          end
        end
        ACCESS: begin
          if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
            if (!lat_write) begin
              readdata_q <= rd_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Combinational so the CPU stalls in the very cycle it raises a strobe.
  assign bus.busywait = !rst &&
                        (((state == IDLE) && (bus.read || bus.write)) || (state == ACCESS));
  assign bus.readdata = readdata_q;

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we      (array_we),
    .wr_addr (lat_addr),
    .wr_data (lat_data),
    .rd_addr (lat_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory with LATENCY=5, DEPTH=256.
module tb_data_memory;
  import dmem_pkg::*;

  localparam int LAT = 5;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   n;

  data_memory_if bus ();

  data_memory #(
    .LATENCY (LAT),
    .DEPTH   (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction; strobes drop after the acceptance edge, when address/data switch to a2/d2.
  // busy returns the number of mid-cycle samples with busywait high (request cycle included).
  task automatic txn(input logic rd, input logic wr, input addr_t a, input data_t d,
                     input addr_t a2, input data_t d2, output int busy);
    @(posedge clk); #1;
    bus.read = rd; bus.write = wr; bus.address = a; bus.writedata = d;
    busy = 0;
    @(negedge clk);
    while (bus.busywait && busy < 40) begin
      busy++;
      @(posedge clk); #1;
      if (busy == 1) begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = a2; bus.writedata = d2;
      end
      @(negedge clk);
    end
    bus.read = 1'b0; bus.write = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 8'h00; bus.writedata = 8'h00;

    // Reset holds busywait low even with a strobe up.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busywait", 32'(bus.busywait), 32'h0);
    check("reset_readdata", 32'(bus.readdata), 32'h00);
    bus.read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back.
    txn(1'b0, 1'b1, 8'h10, 8'hA5, 8'h10, 8'hA5, n);
    check("write_a5_busy_cycles", 32'(n), 32'(LAT + 1));
    txn(1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, n);
    check("read_10_busy_cycles", 32'(n), 32'(LAT + 1));
    check("read_10_data", 32'(bus.readdata), 32'hA5);

    // Inputs changed mid-access must not disturb the latched write.
    txn(1'b0, 1'b1, 8'h20, 8'h99, 8'h20, 8'h99, n);
    check("write_20_busy_cycles", 32'(n), 32'(LAT + 1));
    txn(1'b0, 1'b1, 8'h10, 8'h11, 8'h20, 8'h3C, n);
    check("latched_write_busy_cycles", 32'(n), 32'(LAT + 1));
    txn(1'b1, 1'b0, 8'h10, 8'h00, 8'h10, 8'h00, n);
    check("latched_write_10", 32'(bus.readdata), 32'h11);
    txn(1'b1, 1'b0, 8'h20, 8'h00, 8'h20, 8'h00, n);
    check("latched_write_20_untouched", 32'(bus.readdata), 32'h99);

    // Read and write together: write only, readdata holds 8'h99.
    txn(1'b1, 1'b1, 8'h05, 8'h77, 8'h05, 8'h77, n);
    check("rw_both_busy_cycles", 32'(n), 32'(LAT + 1));
    check("rw_both_readdata_held", 32'(bus.readdata), 32'h99);
    txn(1'b1, 1'b0, 8'h05, 8'h00, 8'h05, 8'h00, n);
    check("rw_both_mem_05", 32'(bus.readdata), 32'h77);

    // Reset two edges into a write of 8'hFF to 8'h30 aborts it.
    txn(1'b0, 1'b1, 8'h30, 8'h42, 8'h30, 8'h42, n);
    @(posedge clk); #1;
    bus.write = 1'b1; bus.address = 8'h30; bus.writedata = 8'hFF;
    @(posedge clk); #1;
    bus.write = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_busywait", 32'(bus.busywait), 32'h0);
    check("abort_readdata", 32'(bus.readdata), 32'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    txn(1'b1, 1'b0, 8'h30, 8'h00, 8'h30, 8'h00, n);
    check("post_reset_read_busy_cycles", 32'(n), 32'(LAT + 1));
`ifdef DMEM_CLEAR_ON_RESET_EN
    check("abort_mem_30", 32'(bus.readdata), 32'h00);
`else
    check("abort_mem_30", 32'(bus.readdata), 32'h42);
`endif

    // Back-to-back writes with the strobe held across the completion edge.
    @(posedge clk); #1;
    bus.write = 1'b1; bus.address = 8'h01; bus.writedata = 8'h61;
    @(posedge clk); #1;
    repeat (LAT) @(posedge clk);
    #1;
    bus.address = 8'h02; bus.writedata = 8'h62;
    @(negedge clk);
    check("b2b_gap_busywait", 32'(bus.busywait), 32'h1);
    @(posedge clk); #1;
    bus.write = 1'b0;
    n = 0;
    @(negedge clk);
    while (bus.busywait && n < 40) begin
      n++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check("b2b_second_access_cycles", 32'(n), 32'(LAT));
    txn(1'b1, 1'b0, 8'h01, 8'h00, 8'h01, 8'h00, n);
    check("b2b_mem_01", 32'(bus.readdata), 32'h61);
    txn(1'b1, 1'b0, 8'h02, 8'h00, 8'h02, 8'h00, n);
    check("b2b_mem_02", 32'(bus.readdata), 32'h62);

    // Top address.
    txn(1'b0, 1'b1, 8'hFF, 8'h5A, 8'hFF, 8'h5A, n);
    txn(1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00, n);
    check("top_addr_ff", 32'(bus.readdata), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter LATENCY, default 5: number of CLK cycles from request acceptance to completion; legal range 1..15.
REQ-002 Parameter DEPTH, default 256: number of 8-bit words in the array.
REQ-003 CLK  input  1  single clock for all state; rising-edge active.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 READ  input  1  read request from the CPU.
REQ-006 WRITE  input  1  write request from the CPU.
REQ-007 ADDRESS  input  8  byte address; the CPU drives it from its ALU result.
REQ-008 WRITEDATA  input  8  store data; the CPU drives it from its register read port 1.
REQ-009 READDATA  output  8  load data returned to the CPU.
REQ-010 BUSYWAIT  output  1  stall request to the CPU; high while a transaction is pending.

Function
REQ-011 The FSM SHALL have two states: IDLE and ACCESS, plus a 4-bit cycle counter.
REQ-012 In IDLE, READ or WRITE high at a rising CLK edge SHALL accept the request, enter ACCESS and clear the counter.
REQ-013 On acceptance, the block SHALL latch ADDRESS, WRITEDATA and the request type; later input changes do not affect the transaction.
REQ-014 BUSYWAIT SHALL be combinational: high when (IDLE and (READ or WRITE)) or in ACCESS, so the CPU stalls in the same cycle as its request.
REQ-015 In ACCESS, the counter SHALL increment once per cycle.
REQ-016 At the edge where the counter equals LATENCY-1, the block SHALL:
  - complete the transaction and return to IDLE;
  - deassert BUSYWAIT;
  - this is exactly LATENCY edges after acceptance.
REQ-017 On read completion, READDATA SHALL load mem[latched address] and hold it until the next read completes or reset.
REQ-018 On write completion, mem[latched address] SHALL take the latched data; READDATA SHALL be unchanged.
REQ-019 If READ and WRITE are both high at acceptance, the block SHALL perform the write only; READDATA is unchanged.
REQ-020 A request still high in IDLE after completion SHALL be treated as a new transaction (the CPU drops its strobes when BUSYWAIT falls).
REQ-021 Addresses at or above DEPTH SHALL wrap modulo DEPTH.
REQ-022 The block SHALL NOT accept a new request while in ACCESS.

Reset
REQ-023 While RESET is high, the block SHALL hold state at IDLE, the counter at 0, READDATA at 8'h00, and BUSYWAIT at 0 regardless of READ or WRITE.
REQ-024 Reset asserted mid-ACCESS SHALL abort the transaction: no array write and no READDATA update.
REQ-025 After reset releases, the first rising edge with a request SHALL accept normally.

Configuration
REQ-026 Macro DMEM_CLEAR_ON_RESET_EN SHALL control array contents on reset.
  - Defined: the asynchronous reset clears every array word to 8'h00.
  - Undefined: array contents are retained across reset; power-up contents are X.

Structure
REQ-027 Shared package dmem_pkg SHALL hold:
  - the state enumeration (IDLE, ACCESS);
  - the data width (8) and address width (8);
  - the default LATENCY and DEPTH constants.
REQ-028 Storage SHALL be a sub-module, dmem_array:
  - one synchronous write port and one read port;
  - the array clear from REQ-026.
  The FSM, counter and latches SHALL live in data_memory.

Verification
REQ-029 Write 8'hA5 to address 8'h10 (LATENCY=5) -> BUSYWAIT high in the request cycle and for 5 edges, then low; mem[8'h10]=8'hA5.
REQ-030 Read address 8'h10 after REQ-029 -> BUSYWAIT high for 5 edges; READDATA=8'hA5 from the completion edge onward.
REQ-031 Change ADDRESS to 8'h20 and WRITEDATA to 8'h3C mid-ACCESS of a write to 8'h10 with 8'h11 -> mem[8'h10]=8'h11; mem[8'h20] unchanged.
REQ-032 READ and WRITE both high, ADDRESS 8'h05, WRITEDATA 8'h77 -> mem[8'h05]=8'h77; READDATA holds its previous value.
REQ-033 RESET pulsed 2 cycles into a write of 8'hFF to 8'h30 -> BUSYWAIT falls immediately, READDATA=8'h00, mem[8'h30] not written; a later read of 8'h30 completes normally.
REQ-034 Back-to-back writes to 8'h01 then 8'h02, with WRITE held high across the completion edge -> two separate 5-cycle transactions, both words written.
